// File: rtl/measure_rd.sv
// measure_rd: consumer end of the measure result-write interface.
// Buffers 64-bit result words in a DEPTH-entry FIFO. The bus side drains
// them through a word-serial 32-bit request/acknowledge read port.
// Optional feature macro: MEASURE_RD_TS_EN. When it is defined, each entry
// carries a 32-bit cycle timestamp, which is read back as a third word.
module measure_rd #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          reg_wr_en_i,
  input  logic [63:0]   reg_wr_data_i,
  input  logic          rd_req_i,
  output logic [31:0]   rd_data_o,
  output logic          rd_ack_o,
  output logic          rd_err_o,
  input  logic          clr_i,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          ovf_o
);

`ifdef MEASURE_RD_TS_EN
  localparam int EW = 96;
`else
  localparam int EW = 64;
`endif

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {PH_LO = 2'd0, PH_HI = 2'd1, PH_TS = 2'd2} phase_e;

`ifdef MEASURE_RD_TS_EN
  localparam phase_e PH_LAST = PH_TS;
`else
  localparam phase_e PH_LAST = PH_HI;
`endif

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  phase_e        phase_q, phase_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_ack_q, rd_ack_d;
  logic          rd_err_q, rd_err_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  logic [EW-1:0] head;
  logic [EW-1:0] wr_entry;
  logic          is_empty;
  logic          pop;
  logic          wr_acc;

`ifdef MEASURE_RD_TS_EN
  logic [31:0] cnt_q, cnt_d;
  assign wr_entry = {cnt_q, reg_wr_data_i};
`else
  assign wr_entry = reg_wr_data_i;
`endif

  assign head     = mem_q[rd_ptr_q];
  assign is_empty = (level_q == '0);
  // A pop on the final word frees a slot, so a write arriving in the same cycle
  // is accepted even when the FIFO is full.
  assign pop      = rd_req_i && !is_empty && !clr_i && (phase_q == PH_LAST);
  assign wr_acc   = reg_wr_en_i && !clr_i && ((level_q != DEPTH_L) || pop);

  // Entry storage. It has no reset; validity is tracked by the level counter.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Next-state logic for the pointers, level, read phase, read port and status.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    phase_d   = phase_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = 1'b0;
    rd_err_d  = 1'b0;
    ovf_d     = ovf_q;
`ifdef MEASURE_RD_TS_EN
    cnt_d     = cnt_q + 32'd1;
`endif
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      phase_d  = PH_LO;
      ovf_d    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else if (reg_wr_en_i) begin
        ovf_d = 1'b1;
      end
      if (rd_req_i) begin
        rd_ack_d = 1'b1;
        if (is_empty) begin
          rd_data_d = '0;
          rd_err_d  = 1'b1;
        end else begin
          case (phase_q)
            PH_LO: begin
              rd_data_d = head[31:0];
              phase_d   = PH_HI;
            end
            PH_HI: begin
              rd_data_d = head[63:32];
`ifdef MEASURE_RD_TS_EN
              phase_d   = PH_TS;
`else
              phase_d   = PH_LO;
              rd_ptr_d  = rd_ptr_q + 1'b1;
`endif
            end
`ifdef MEASURE_RD_TS_EN
            PH_TS: begin
              rd_data_d = head[95:64];
              phase_d   = PH_LO;
              rd_ptr_d  = rd_ptr_q + 1'b1;
            end
`endif
            default: phase_d = PH_LO;
          endcase
        end
      end
      case ({wr_acc, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);
  end

  // State registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      phase_q   <= PH_LO;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef MEASURE_RD_TS_EN
      cnt_q     <= '0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      phase_q   <= phase_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
`ifdef MEASURE_RD_TS_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_ack_o  = rd_ack_q;
  assign rd_err_o  = rd_err_q;
  assign level_o   = level_q;
  assign empty_o   = empty_q;
  assign full_o    = full_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_measure_rd.sv
// Bench for measure_rd in its default build (DEPTH=8, no timestamp).
// Each issued read pushes its expected {err, data} pair into a queue.
// A monitor pops one pair and compares it on every acknowledge.
module tb_measure_rd;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          reg_wr_en_i = 1'b0;
  logic [63:0]   reg_wr_data_i = '0;
  logic          rd_req_i = 1'b0;
  logic [31:0]   rd_data_o;
  logic          rd_ack_o;
  logic          rd_err_o;
  logic          clr_i = 1'b0;
  logic [AW:0]   level_o;
  logic          empty_o;
  logic          full_o;
  logic          ovf_o;

  int n_vec  = 0;
  int n_miss = 0;
  logic [32:0] exp_q[$];

  measure_rd #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .reg_wr_en_i(reg_wr_en_i), .reg_wr_data_i(reg_wr_data_i),
    .rd_req_i(rd_req_i), .rd_data_o(rd_data_o), .rd_ack_o(rd_ack_o),
    .rd_err_o(rd_err_o), .clr_i(clr_i), .level_o(level_o),
    .empty_o(empty_o), .full_o(full_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: each acknowledge is compared with the oldest expected response.
  always @(negedge clk_i) begin
    if (rst_n_i && rd_ack_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_ack: got data %0h err %0b expected no ack", rd_data_o, rd_err_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        n_vec++;
        if ({rd_err_o, rd_data_o} !== e) begin
          n_miss++;
          $display("FAIL read: got err %0b data %08h expected err %0b data %08h",
                   rd_err_o, rd_data_o, e[32], e[31:0]);
        end else begin
          $display("ok   read: err %0b data %08h", rd_err_o, rd_data_o);
        end
      end
    end else if (rst_n_i && rd_err_o) begin
      n_vec++;
      n_miss++;
      $display("FAIL err_without_ack: got rd_err_o=1 expected 0");
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [63:0] d);
    reg_wr_en_i = 1'b1;
    reg_wr_data_i = d;
    tick();
    reg_wr_en_i = 1'b0;
  endtask

  task automatic do_read(input logic err, input logic [31:0] d);
    rd_req_i = 1'b1;
    exp_q.push_back({err, d});
    tick();
    rd_req_i = 1'b0;
  endtask

  function automatic logic [63:0] wa(input int i);
    return {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
  endfunction
  function automatic logic [63:0] wb(input int i);
    return {32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i)};
  endfunction
  function automatic logic [63:0] wc(input int i);
    return {32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i)};
  endfunction

  initial begin
    logic [63:0] x;
    // Reset state.
    repeat (3) tick();
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full",  64'(full_o),  64'd0);
    chk("rst_ovf",   64'(ovf_o),   64'd0);
    chk("rst_ack",   64'(rd_ack_o), 64'd0);
    chk("rst_data",  64'(rd_data_o), 64'd0);
    rst_n_i = 1'b1;
    tick();

    // A read from an empty FIFO returns an error and zero data.
    do_read(1'b1, 32'h0);
    chk("empty_rd_level", 64'(level_o), 64'd0);

    // A single entry is read back as the low word, then the high word.
    do_write(64'h0000_0123_0000_ABCD);
    chk("one_level", 64'(level_o), 64'd1);
    do_read(1'b0, 32'h0000_ABCD);
    do_read(1'b0, 32'h0000_0123);
    chk("one_empty", 64'(empty_o), 64'd1);

    // Nine writes to a depth-8 FIFO overflow it; the ninth is dropped.
    for (int i = 0; i < 9; i++) do_write(wa(i));
    chk("ovf_level", 64'(level_o), 64'(DEPTH));
    chk("ovf_full",  64'(full_o), 64'd1);
    chk("ovf_flag",  64'(ovf_o),  64'd1);
    for (int i = 0; i < 8; i++) begin
      x = wa(i);
      do_read(1'b0, x[31:0]);
      do_read(1'b0, x[63:32]);
    end
    chk("drain_empty", 64'(empty_o), 64'd1);
    chk("ovf_sticky",  64'(ovf_o),  64'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_ovf", 64'(ovf_o), 64'd0);

    // With the FIFO full, a write coinciding with the final-word read is accepted.
    for (int i = 0; i < 8; i++) do_write(wb(i));
    x = wb(0);
    do_read(1'b0, x[31:0]);
    chk("full_before", 64'(level_o), 64'(DEPTH));
    rd_req_i = 1'b1;
    reg_wr_en_i = 1'b1;
    reg_wr_data_i = 64'h0BAD_F00D_1234_5678;
    exp_q.push_back({1'b0, x[63:32]});
    tick();
    rd_req_i = 1'b0;
    reg_wr_en_i = 1'b0;
    chk("pass_level", 64'(level_o), 64'(DEPTH));
    chk("pass_full",  64'(full_o), 64'd1);
    chk("pass_ovf",   64'(ovf_o),  64'd0);
    for (int i = 1; i < 8; i++) begin
      x = wb(i);
      do_read(1'b0, x[31:0]);
      do_read(1'b0, x[63:32]);
    end
    do_read(1'b0, 32'h1234_5678);
    do_read(1'b0, 32'h0BAD_F00D);
    chk("pass_empty", 64'(empty_o), 64'd1);

    // A clear issued mid-entry discards the data and resets the read phase.
    for (int i = 0; i < 3; i++) do_write(wc(i));
    x = wc(0);
    do_read(1'b0, x[31:0]);
    rd_req_i = 1'b1;
    clr_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    clr_i = 1'b0;
    chk("clr_ack",   64'(rd_ack_o), 64'd0);
    chk("clr_hold",  64'(rd_data_o), 64'(x[31:0]));
    chk("clr_level", 64'(level_o), 64'd0);
    chk("clr_empty", 64'(empty_o), 64'd1);
    chk("clr_ovf2",  64'(ovf_o), 64'd0);
    do_write(64'hDEAD_BEEF_CAFE_F00D);
    do_read(1'b0, 32'hCAFE_F00D);
    do_read(1'b0, 32'hDEAD_BEEF);
    chk("new_empty", 64'(empty_o), 64'd1);

    // Every issued read must have been acknowledged by now.
    repeat (3) tick();
    chk("pending_acks", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/measure_rd.md
Name: measure_rd

Overview:
- Consumer end of the measure result-write interface.
- Captures each 64-bit result word written by measure (reg_wr_en/reg_wr_data) into a small FIFO.
- Presents the results to the register/bus side as a word-serial 32-bit read port with request/acknowledge handshake.
- Reports level, empty/full and sticky overflow status so software can drain results without losing gate periods.

Parameters:
- DEPTH, 8, number of 64-bit entries; power of two, 2..256.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_i  in  1  system clock (same domain as measure).
- rst_n_i  in  1  asynchronous active-low reset.
- reg_wr_en_i  in  1  one-cycle write strobe from measure.
- reg_wr_data_i  in  64  result word from measure; [31:0] low word, [63:32] high word.
- rd_req_i  in  1  one-cycle read request for the next 32-bit word.
- rd_data_o  out  32  read data; valid while rd_ack_o=1, held afterwards.
- rd_ack_o  out  1  one-cycle acknowledge, one clock after rd_req_i.
- rd_err_o  out  1  one-cycle pulse with rd_ack_o when the request hit an empty FIFO.
- clr_i  in  1  synchronous clear of FIFO and status.
- level_o  out  AW+1  number of stored entries, 0..DEPTH.
- empty_o  out  1  level_o==0.
- full_o  out  1  level_o==DEPTH.
- ovf_o  out  1  sticky: a write was dropped.

Behaviour:
- Reset (async, rst_n_i=0):
  - wr_ptr=rd_ptr=0, word phase=0, level_o=0.
  - empty_o=1, full_o=0, ovf_o=0.
  - rd_ack_o=0, rd_err_o=0, rd_data_o=0.
  - Reset mid-read discards the partially read entry.
- Write:
  - Triggers on any cycle with reg_wr_en_i=1.
  - Accepted when level<DEPTH, or when the same cycle pops an entry (final-word read).
  - Accepted write: entry[wr_ptr]<=reg_wr_data_i, wr_ptr++ (wraps mod DEPTH).
  - Otherwise the write is dropped and ovf_o<=1.
- Read state machine; phase counts words within the head entry:
  - PH_LO: rd_req_i && !empty → rd_data_o<=entry[rd_ptr][31:0], go to PH_HI.
  - PH_HI: rd_req_i && !empty → rd_data_o<=entry[rd_ptr][63:32], pop (rd_ptr++, level--), go to PH_LO.
  - rd_req_i && empty → rd_data_o<=0, rd_err_o=1, phase unchanged.
  - In every case rd_ack_o=1 on the next cycle; latency is exactly 1 clock.
  - Back-to-back requests on consecutive cycles are legal; each is acked.
- Level update:
  - Accepted write together with pop: level unchanged.
  - Write only: +1.
  - Pop only: −1.
  - level_o, empty_o and full_o are registered and reflect the new level the cycle after the event.
- clr_i:
  - Highest priority over write and read in the same cycle.
  - Pointers, phase and level return to 0 and ovf_o<=0.
  - No rd_ack_o for a request coinciding with clr_i.
  - rd_data_o is held.
- Wrap-around: pointers are AW bits; level is tracked separately, so full and empty are unambiguous at DEPTH.
- rd_data_o holds its last value until the next acked request.

Optional Feature:
- Macro MEASURE_RD_TS_EN.
- When defined:
  - A free-running 32-bit cycle counter (reset 0, wraps at 2^32−1→0) is captured with each accepted write into a 96-bit entry.
  - The read sequence becomes PH_LO → PH_HI → PH_TS; pop happens on PH_TS.
  - PH_TS returns the counter value from the cycle reg_wr_en_i was accepted.
- When undefined: no counter, 64-bit entries, two-word sequence exactly as above.

Test Plan:
- Reset then rd_req_i pulse with FIFO empty → next cycle rd_ack_o=1, rd_err_o=1, rd_data_o=0x00000000, level_o stays 0.
- Write 0x0000_0123_0000_ABCD, then two rd_req_i pulses → acks return 0x0000ABCD then 0x00000123; empty_o=1 after the second.
- Write 9 words with DEPTH=8 and no reads → level_o=8, full_o=1, ovf_o=1; draining 16 words returns the first 8 entries in order.
- FIFO full plus a write in the same cycle as the final-word read → write accepted, level_o stays 8, ovf_o stays 0.
- Stored words 3, rd_req_i and clr_i asserted together → no ack, level_o=0, ovf_o=0; a subsequent write/read returns the new data.
- With MEASURE_RD_TS_EN: write at cycle 100 after reset → third read word = 100; empty_o=1 only after the third read.
